// File: rtl/i2s_pkg.sv
// i2s_pkg: shared frame constants and receiver FSM state type
package i2s_pkg;
   localparam int FRAME_BITS = 64;
   localparam int HALF_BITS  = 32;
   typedef enum logic {HUNT, RUN} state_t;
endpackage

// File: rtl/i2s_shift.sv
// i2s_shift: MSB-first serial-in shift register for one channel
module i2s_shift #(
   parameter int WIDTH = 24
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             sd,
   output logic [WIDTH-1:0] q
);
   // clear wins over shifting so a resync always starts from an empty register
   always_ff @(posedge ck or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clear) q <= '0;
      else if (shift_en) q <= {q[WIDTH-2:0], sd};
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver capturing WIDTH-bit stereo pairs with valid/ready output
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic             ck,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sck,
   input  logic             ws,
   input  logic [5:0]       frame_posn,
   input  logic             sd,
   output logic [WIDTH-1:0] left,
   output logic [WIDTH-1:0] right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             sync_err,
   input  logic             clr_err
);
   localparam logic [4:0] LAST = 5'(WIDTH);
   state_t state;
   logic sck_d;
   logic [WIDTH-1:0] lq, rq, lhold;
   logic rise, chan, live, mismatch, run_ok, bit_ok, at_last, left_done, pair_done, accept;
   logic [4:0] idx;
   assign rise      = sck & ~sck_d;
   assign chan      = frame_posn[5];
   assign idx       = frame_posn[4:0];
   assign live      = (state == RUN) & en & rise;
   assign mismatch  = live & (ws != chan);
   assign run_ok    = live & (ws == chan);
   assign bit_ok    = run_ok & (idx != 5'd0) & (idx <= LAST);
   assign at_last   = run_ok & (idx == LAST);
   assign left_done = at_last & ~chan;
   assign pair_done = at_last & chan;
   assign accept    = pair_done & (~out_valid | out_ready);
   i2s_shift #(.WIDTH(WIDTH)) u_left (
      .ck(ck), .rst_n(rst_n), .clear(state == HUNT), .shift_en(bit_ok & ~chan), .sd(sd), .q(lq)
   );
   i2s_shift #(.WIDTH(WIDTH)) u_right (
      .ck(ck), .rst_n(rst_n), .clear(state == HUNT), .shift_en(bit_ok & chan), .sd(sd), .q(rq)
   );
   // edge detector, HUNT/RUN sequencing and sticky framing error
   always_ff @(posedge ck or negedge rst_n)
      if (!rst_n) begin
         sck_d    <= 1'b0;
         state    <= HUNT;
         sync_err <= 1'b0;
      end else begin
         sck_d    <= sck;
         state    <= (state == HUNT) ? ((rise && en && frame_posn == 6'd0) ? RUN : HUNT)
                                     : ((!en || mismatch) ? HUNT : RUN);
         sync_err <= mismatch | (sync_err & ~clr_err);
      end
   // left sample waits here (including the final bit) until the right one completes
   always_ff @(posedge ck or negedge rst_n)
      if (!rst_n) lhold <= '0;
      else if (state == HUNT) lhold <= '0;
      else if (left_done) lhold <= {lq[WIDTH-2:0], sd};
   // output pair handshake; a pair arriving while the old one is unread is dropped
   always_ff @(posedge ck or negedge rst_n)
      if (!rst_n) begin
         left      <= '0;
         right     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (accept) begin
            left  <= lhold;
            right <= {rq[WIDTH-2:0], sd};
         end
         out_valid <= accept | (out_valid & ~out_ready);
         overrun   <= (pair_done & out_valid & ~out_ready) | (overrun & ~clr_err);
      end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx driving an I2S clock generator model (DIVIDER = 12)
module tb_i2s_rx;
   logic ck = 1'b0, rst_n = 1'b0, en = 1'b0, sck = 1'b0, ws = 1'b0, sd = 1'b0, sd16 = 1'b1;
   logic out_ready = 1'b0, clr_err = 1'b0, ws_inv = 1'b0;
   logic [5:0] frame_posn = 6'd0;
   logic [23:0] left, right, cl = '0, cr = '0;
   logic [15:0] left16, right16, cl16 = '0, cr16 = '0;
   logic out_valid, overrun, sync_err, v16, ov16, se16;
   int tests = 0, fails = 0;

   i2s_rx #(.WIDTH(24)) u24 (
      .ck(ck), .rst_n(rst_n), .en(en), .sck(sck), .ws(ws), .frame_posn(frame_posn), .sd(sd),
      .left(left), .right(right), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun), .sync_err(sync_err), .clr_err(clr_err)
   );
   i2s_rx #(.WIDTH(16)) u16 (
      .ck(ck), .rst_n(rst_n), .en(en), .sck(sck), .ws(ws), .frame_posn(frame_posn), .sd(sd16),
      .left(left16), .right(right16), .out_valid(v16), .out_ready(out_ready),
      .overrun(ov16), .sync_err(se16), .clr_err(clr_err)
   );

   always #5 ck = ~ck;

   initial begin
      #3ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // low half of one sck period: present position, ws and data bit
   task automatic bit_lo(input int p);
      int k;
      logic ch;
      k  = p % 32;
      ch = (p >= 32);
      @(negedge ck);
      sck        = 1'b0;
      frame_posn = 6'(p);
      ws         = ch ^ ws_inv;
      sd         = (k >= 1 && k <= 24) ? (ch ? cr[24-k] : cl[24-k]) : 1'b0;
      sd16       = (k >= 1 && k <= 16) ? (ch ? cr16[16-k] : cl16[16-k]) : 1'b1;
      repeat (5) @(negedge ck);
   endtask

   task automatic bit_hi();
      @(negedge ck);
      sck = 1'b1;
      repeat (5) @(negedge ck);
   endtask

   task automatic send_bits(input int a, input int b);
      for (int p = a; p <= b; p++) begin
         bit_lo(p);
         bit_hi();
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic [15:0] l16, input logic [15:0] r16);
      cl = l; cr = r; cl16 = l16; cr16 = r16;
      send_bits(0, 63);
   endtask

   task automatic consume();
      @(negedge ck) out_ready = 1'b1;
      @(negedge ck) out_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge ck) clr_err = 1'b1;
      @(negedge ck) clr_err = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge ck);
      tests++; if (left !== 24'h0) begin fails++; $display("FAIL reset_left got %h want 000000", left); end
      tests++; if (right !== 24'h0) begin fails++; $display("FAIL reset_right got %h want 000000", right); end
      tests++; if ({out_valid, overrun, sync_err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {out_valid, overrun, sync_err}); end
      tests++; if ({v16, ov16, se16} !== 3'b000) begin fails++; $display("FAIL reset_flags16 got %b want 000", {v16, ov16, se16}); end
      @(negedge ck) rst_n = 1'b1;
      en = 1'b1;
   endtask

   task automatic test_basic();
      cl = 24'hA5A5A5; cr = 24'h123456; cl16 = 16'h1234; cr16 = 16'hABCD;
      send_bits(0, 55);
      bit_lo(56);
      @(negedge ck);
      sck = 1'b1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
      @(negedge ck);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid); end
      tests++; if (left !== 24'hA5A5A5) begin fails++; $display("FAIL basic_left got %h want a5a5a5", left); end
      tests++; if (right !== 24'h123456) begin fails++; $display("FAIL basic_right got %h want 123456", right); end
      repeat (4) @(negedge ck);
      send_bits(57, 63);
      consume();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_consume got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      send_frame(24'h800000, 24'h7FFFFF, 16'h0F0F, 16'hF0F0);
      tests++; if ({left, right} !== {24'h800000, 24'h7FFFFF}) begin fails++; $display("FAIL b2b_first got %h %h want 800000 7fffff", left, right); end
      send_frame(24'h000001, 24'hFFFFFF, 16'h0F0F, 16'hF0F0);
      tests++; if ({left, right} !== {24'h000001, 24'hFFFFFF}) begin fails++; $display("FAIL b2b_second got %h %h want 000001 ffffff", left, right); end
      tests++; if ({out_valid, overrun} !== 2'b00) begin fails++; $display("FAIL b2b_flags got %b want 00", {out_valid, overrun}); end
      out_ready = 1'b0;
   endtask

   task automatic test_en_mid();
      en = 1'b0;
      cl = 24'hFFFFFF; cr = 24'hEEEEEE;
      send_bits(0, 39);
      en = 1'b1;
      send_bits(40, 63);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL en_mid_valid got %b want 0", out_valid); end
      tests++; if (left !== 24'h000001) begin fails++; $display("FAIL en_mid_left got %h want 000001", left); end
      send_frame(24'h111111, 24'h222222, 16'h0000, 16'h0000);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL en_first_valid got %b want 1", out_valid); end
      tests++; if ({left, right} !== {24'h111111, 24'h222222}) begin fails++; $display("FAIL en_first_pair got %h %h want 111111 222222", left, right); end
      consume();
   endtask

   task automatic test_overrun();
      send_frame(24'hABCDEF, 24'hFEDCBA, 16'h0000, 16'h0000);
      tests++; if ({out_valid, overrun} !== 2'b10) begin fails++; $display("FAIL ovr_first got %b want 10", {out_valid, overrun}); end
      send_frame(24'h010203, 24'h040506, 16'h0000, 16'h0000);
      tests++; if ({left, right} !== {24'hABCDEF, 24'hFEDCBA}) begin fails++; $display("FAIL ovr_hold got %h %h want abcdef fedcba", left, right); end
      tests++; if ({out_valid, overrun} !== 2'b11) begin fails++; $display("FAIL ovr_flags got %b want 11", {out_valid, overrun}); end
      pulse_clr();
      tests++; if ({overrun, ov16} !== 2'b00) begin fails++; $display("FAIL ovr_clear got %b want 00", {overrun, ov16}); end
      consume();
   endtask

   task automatic test_sync();
      cl = 24'hABABAB; cr = 24'hCDCDCD;
      send_bits(0, 9);
      ws_inv = 1'b1;
      bit_lo(10);
      bit_hi();
      ws_inv = 1'b0;
      send_bits(11, 63);
      tests++; if (sync_err !== 1'b1) begin fails++; $display("FAIL sync_set got %b want 1", sync_err); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sync_no_pair got %b want 0", out_valid); end
      send_frame(24'h5A5A5A, 24'h3C3C3C, 16'h0000, 16'h0000);
      tests++; if ({out_valid, left, right} !== {1'b1, 24'h5A5A5A, 24'h3C3C3C}) begin fails++; $display("FAIL sync_resume got %b %h %h want 1 5a5a5a 3c3c3c", out_valid, left, right); end
      pulse_clr();
      tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL sync_clear got %b want 0", sync_err); end
      consume();
   endtask

   task automatic test_reset_mid();
      send_frame(24'h777777, 24'h888888, 16'h0000, 16'h0000);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
      send_bits(0, 49);
      bit_lo(50);
      #1 rst_n = 1'b0;
      #1;
      tests++; if ({out_valid, left, right} !== 49'h0) begin fails++; $display("FAIL rst_async got %b %h %h want 0 000000 000000", out_valid, left, right); end
      @(negedge ck) rst_n = 1'b1;
      bit_hi();
      send_bits(51, 63);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_no_pair got %b want 0", out_valid); end
      send_frame(24'h246802, 24'h135791, 16'h0000, 16'h0000);
      tests++; if ({out_valid, left, right} !== {1'b1, 24'h246802, 24'h135791}) begin fails++; $display("FAIL rst_resume got %b %h %h want 1 246802 135791", out_valid, left, right); end
      consume();
   endtask

   task automatic test_width16();
      send_frame(24'h000000, 24'h000000, 16'h8001, 16'h7FFE);
      tests++; if (v16 !== 1'b1) begin fails++; $display("FAIL w16_valid got %b want 1", v16); end
      tests++; if (left16 !== 16'h8001) begin fails++; $display("FAIL w16_left got %h want 8001", left16); end
      tests++; if (right16 !== 16'h7FFE) begin fails++; $display("FAIL w16_right got %h want 7ffe", right16); end
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_en_mid();
      test_overrun();
      test_sync();
      test_reset_mid();
      test_width16();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
